// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the serial operand feeder.
package serial_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-right register; bit 0 is the serial output.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_serial
);

    logic [WIDTH-1:0] r_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {1'b0, r_sh[WIDTH-1:1]};
        end
    end

    assign o_serial = r_sh[0];

endmodule

// File: rtl/serial_operand_serializer.sv
// Accepts an operand pair and streams both LSB-first for a bit-serial adder,
// with one mandatory carry-clear IDLE cycle between operations.
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
    output logic             carry_clr
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_operand_serializer: WIDTH must be >= 2");
    end

    ser_state_t    r_state;
    ser_state_t    w_next_state;
    logic [CW-1:0] r_cnt;
    logic          w_load;
    logic          w_shift;
    logic          w_last;
    logic          w_a_ser;
    logic          w_b_ser;

    // in_valid only reaches register enables, never an output.
    assign w_load  = (r_state == SER_IDLE) && in_valid;
    assign w_shift = (r_state == SER_SHIFT);
    assign w_last  = w_shift && (r_cnt == LAST_CNT);

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_data   (in_a),
        .o_serial (w_a_ser)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_shift  (w_shift),
        .i_data   (in_b),
        .o_serial (w_b_ser)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SER_IDLE:  if (w_load) w_next_state = SER_SHIFT;
            SER_SHIFT: if (w_last) w_next_state = SER_IDLE;
            default:   w_next_state = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load || w_last) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        carry_clr = 1'b1;
        bit_valid = 1'b0;
        a         = 1'b0;
        b         = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        if (!rst) begin
            case (r_state)
                SER_IDLE: begin
                    in_ready  = 1'b1;
                    carry_clr = 1'b1;
                end
                SER_SHIFT: begin
                    carry_clr = 1'b0;
                    bit_valid = 1'b1;
                    a         = w_a_ser;
                    b         = w_b_ser;
                    first     = (r_cnt == '0);
                    last      = (r_cnt == LAST_CNT);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Directed bench for serial_operand_serializer with a bit-index reference model
// and a downstream bit-serial adder whose carry resets on rst | carry_clr.
module tb_serial_operand_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         a, b, bit_valid, first, last, carry_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    serial_operand_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .a         (a),
        .b         (b),
        .bit_valid (bit_valid),
        .first     (first),
        .last      (last),
        .carry_clr (carry_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: busy flag plus index of the bit currently on the wire.
    logic         m_busy = 1'b0;
    int           m_pos  = 0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_pos  = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_a    = in_a;
                m_b    = in_b;
                m_pos  = 0;
                m_busy = 1'b1;
            end
        end else if (m_pos == W - 1) begin
            m_busy = 1'b0;
        end else begin
            m_pos++;
        end
    end

    always @(negedge clk) begin
        logic live;
        live = !rst && m_busy;
        chk("in_ready",  in_ready,  !rst && !m_busy);
        chk("carry_clr", carry_clr, rst || !m_busy);
        chk("bit_valid", bit_valid, live);
        chk("a",         a,         live ? m_a[m_pos] : 1'b0);
        chk("b",         b,         live ? m_b[m_pos] : 1'b0);
        chk("first",     first,     live && (m_pos == 0));
        chk("last",      last,      live && (m_pos == W - 1));
    end

    // Downstream bit-serial adder.
    logic carry = 1'b0;
    logic sum_bit;
    assign sum_bit = a ^ b ^ carry;
    always @(posedge clk) begin
        if (rst || carry_clr) carry <= 1'b0;
        else if (bit_valid)   carry <= (a & b) | (a & carry) | (b & carry);
    end

    int first_q[$];
    always @(negedge clk) if (first) first_q.push_back(cyc);

    task automatic wait_ready(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) chk({nm, "_ready_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input bit toggle, output logic [W-1:0] ra, output logic [W-1:0] rb,
                          output logic [W-1:0] rs);
        in_a = va; in_b = vb; in_valid = 1'b1;
        wait_ready(nm);
        @(posedge clk); #2;
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            ra[i] = a; rb[i] = b; rs[i] = sum_bit;
            chk({nm, "_bv"},    bit_valid, 1);
            chk({nm, "_first"}, first, (i == 0));
            chk({nm, "_last"},  last,  (i == W - 1));
            if (toggle) begin
                in_valid = i[0];
                in_a = W'($urandom);
                in_b = W'($urandom);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_idle_bv"},  bit_valid, 0);
        chk({nm, "_idle_clr"}, carry_clr, 1);
        chk({nm, "_idle_rdy"}, in_ready,  1);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rs;

        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, rs;

        // Reset behaviour, including mid-cycle assertion.
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", in_ready, 1);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_async_ready", in_ready, 0);
        chk("rst_async_clr",   carry_clr, 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_release2_ready", in_ready, 1);

        // Single operation.
        run_op("op1", 8'hA5, 8'h3C, 1'b0, ra, rb, rs);
        chk("op1_a_stream", ra, 8'hA5);
        chk("op1_b_stream", rb, 8'h3C);

        // Continuous in_valid, four pairs.
        @(posedge clk); #2;
        first_q.delete();
        in_valid = 1'b1;
        in_a = 8'h11; in_b = 8'h22;
        for (int k = 0; k < 28; k++) begin
            @(posedge clk); #2;
            in_a = in_a + 8'h13;
            in_b = in_b ^ 8'h5A;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        chk("cont_accepts", first_q.size(), 4);
        for (int k = 1; k < first_q.size(); k++)
            chk("cont_spacing", first_q[k] - first_q[k-1], W + 1);

        // Inputs ignored while shifting.
        run_op("busy", 8'h96, 8'h0F, 1'b1, ra, rb, rs);
        chk("busy_a_stream", ra, 8'h96);
        chk("busy_b_stream", rb, 8'h0F);

        // Reset in bit 3 of an operation.
        in_a = 8'hE7; in_b = 8'h18; in_valid = 1'b1;
        wait_ready("rstmid");
        @(posedge clk); #2 in_valid = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("rstmid_bv_before", bit_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_bv",  bit_valid, 0);
        chk("rstmid_clr", carry_clr, 1);
        chk("rstmid_a",   a, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", in_ready, 1);
        run_op("after", 8'h5A, 8'hC3, 1'b0, ra, rb, rs);
        chk("after_a_stream", ra, 8'h5A);
        chk("after_b_stream", rb, 8'hC3);

        // End-to-end with the downstream adder.
        run_op("add1", 8'hFF, 8'h01, 1'b0, ra, rb, rs);
        chk("add_ff_01", rs, 8'h00);
        run_op("add2", 8'h01, 8'h01, 1'b0, ra, rb, rs);
        chk("add_01_01", rs, 8'h02);
        run_op("add3", 8'h3A, 8'h47, 1'b0, ra, rb, rs);
        chk("add_3a_47", rs, 8'h81);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
